// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: MULT, MULTU, DIV and DIVU.
// Computes in WIDTH cycles (shift-add / restoring division) and returns {hi, lo}.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {K_MULT, K_MULTU, K_DIV, K_DIVU, K_ILL} kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d, kind_in;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;            // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic [WIDTH-1:0]   out_lo_q, out_lo_d;

  // Operand decode at the request port
  logic               signed_in, is_div_in, is_mul_in;
  logic [WIDTH-1:0]   a_abs, b_abs;

  always_comb begin
    case (op)
      4'b0001: kind_in = K_MULT;
      4'b0010: kind_in = K_MULTU;
      4'b0100: kind_in = K_DIV;
      4'b1000: kind_in = K_DIVU;
      default: kind_in = K_ILL;
    endcase
  end

  assign signed_in = (kind_in == K_MULT) || (kind_in == K_DIV);
  assign is_div_in = (kind_in == K_DIV) || (kind_in == K_DIVU);
  assign is_mul_in = (kind_in == K_MULT) || (kind_in == K_MULTU);
  assign a_abs     = (signed_in && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_abs     = (signed_in && src_b[WIDTH-1]) ? -src_b : src_b;

  // One shift-add step: acc_hi accumulates, acc_lo shifts out multiplier bits
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // One restoring-division step: acc_hi is the partial remainder, acc_lo
  // shifts dividend bits out at the top and quotient bits in at the bottom
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ge};

  // Sign correction applied on the final iteration
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {mul_hi_n, mul_lo_n};
  assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_lo_q ? -div_lo_n : div_lo_n;
  assign rem_fix  = neg_hi_q ? -div_hi_n : div_hi_n;

  // NOTE: every variable written here gets a hold default first, so no path
  // through the case/if tree leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    out_hi_d = out_hi_q;
    out_lo_d = out_lo_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !cancel) begin
          state_d  = S_CALC;
          kind_d   = kind_in;
          cnt_d    = '0;
          m_d      = is_div_in ? b_abs : a_abs;
          acc_hi_d = '0;
          acc_lo_d = is_div_in ? a_abs : b_abs;
          neg_lo_d = signed_in && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_hi_d = (kind_in == K_DIV) && src_a[WIDTH-1];
          dz_d     = is_div_in && (src_b == '0);
        end
      end

      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          case (kind_q)
            K_MULT, K_MULTU: begin
              acc_hi_d = mul_hi_n;
              acc_lo_d = mul_lo_n;
            end
            K_DIV, K_DIVU: begin
              acc_hi_d = div_hi_n;
              acc_lo_d = div_lo_n;
            end
            default: ;
          endcase

          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            case (kind_q)
              K_MULT, K_MULTU: {out_hi_d, out_lo_d} = prod_fix;
              K_DIV, K_DIVU: begin
                // A zero divisor leaves |a| as the remainder, so the sign
                // correction restores src_a; only the quotient is forced
                out_hi_d = rem_fix;
                out_lo_d = dz_q ? '1 : quo_fix;
              end
              default: begin
                out_hi_d = '0;
                out_lo_d = '0;
              end
            endcase
          end
        end
      end

      S_DONE: begin
        if (cancel || out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      kind_q   <= K_ILL;
      cnt_q    <= '0;
      m_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      out_hi_q <= '0;
      out_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      out_hi_q <= out_hi_d;
      out_lo_q <= out_lo_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_hi    = out_hi_q;
  assign out_lo    = out_lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          cancel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_hi, out_lo;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;

  localparam logic [3:0] OP_MULT = 4'b0001, OP_MULTU = 4'b0010,
                         OP_DIV  = 4'b0100, OP_DIVU  = 4'b1000;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: returns {hi, lo} from plain integer arithmetic
  function automatic logic [2*W-1:0] ref_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [W-1:0] q, r;
    case (o)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = a;
        ib = b;
        q  = ia / ib;
        r  = ia % ib;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a result is actually handed over
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && cancel === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {out_hi, out_lo}, 'x);
      end else begin
        check("result", {out_hi, out_lo}, exp_q.pop_front());
      end
    end
  end

  // Drives a request from an IDLE cycle and returns just after the accept edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    if (push) begin
      last_exp = ref_model(o, a, b);
      exp_q.push_back(last_exp);
    end
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checking latency and busy; drains if out_ready is high
  task automatic wait_result();
    int cyc = 1;
    bit busy_ok = 1'b1;
    while (!out_valid && cyc < 4 * LATENCY) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(LATENCY));
    check("busy_calc", 64'(busy_ok), 64'd1);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(o, a, b, 1'b1);
    wait_result();
  endtask

  initial begin
    logic [2*W-1:0] held;
    bit             quiet, stable;
    logic [3:0]     bad_ops [8];
    logic [3:0]     o;
    logic [W-1:0]   a, b;
    int             sel;

    bad_ops = '{4'b0000, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100, 4'b1111};
    resetn = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    cancel = 1'b0; out_ready = 1'b1; last_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {out_hi, out_lo}, '0);

    // Directed arithmetic corners
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'd100, 32'd7);
    run_op(OP_DIVU,  32'd5, 32'd0);
    run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0);
    run_op(4'b0110,  32'd12, 32'd3);

    // Backpressure: result held in DONE, requests ignored
    out_ready = 1'b0;
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_result();
    held = ref_model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    op = OP_DIVU; src_a = 32'd1000; src_b = 32'd33; in_valid = 1'b1;
    quiet = 1'b1; stable = 1'b1;
    repeat (5) begin
      if (!out_valid || in_ready) quiet = 1'b0;
      if ({out_hi, out_lo} !== held) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_valid_hold", 64'(quiet), 64'd1);
    check("bp_value_hold", 64'(stable), 64'd1);
    out_ready = 1'b1;
    last_exp = ref_model(OP_DIVU, 32'd1000, 32'd33);
    exp_q.push_back(last_exp);
    @(posedge clk); #1;
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b2b_accept", 64'({busy, in_ready}), 64'b10);
    wait_result();

    // Cancel on the 10th CALC edge
    issue(OP_MULTU, 32'd77, 32'd99, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_calc_idle", 64'({busy, in_ready}), 64'b01);
    quiet = 1'b1; stable = 1'b1;
    repeat (2 * LATENCY) begin
      if (out_valid) quiet = 1'b0;
      if ({out_hi, out_lo} !== last_exp) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("cancel_no_valid", 64'(quiet), 64'd1);
    check("cancel_keep_out", 64'(stable), 64'd1);

    // Cancel blocks acceptance in IDLE
    op = OP_MULTU; src_a = 32'd4; src_b = 32'd4; in_valid = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    check("cancel_idle_block", 64'({busy, in_ready}), 64'b01);

    // Cancel in DONE drops the result
    out_ready = 1'b0;
    issue(OP_DIVU, 32'd50, 32'd5, 1'b0);
    wait_result();
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    out_ready = 1'b1;
    check("cancel_done_drop", 64'({out_valid, in_ready}), 64'b01);

    // Reset mid-CALC
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rst_mid_outs", {out_hi, out_lo}, '0);
    check("rst_mid_flags", 64'({out_valid, busy, in_ready}), 64'b001);
    run_op(OP_MULTU, 32'd3, 32'd5);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    o = OP_MULT;
        2, 3:    o = OP_MULTU;
        4, 5:    o = OP_DIV;
        6, 7:    o = OP_DIVU;
        default: o = bad_ops[$urandom_range(0, 7)];
      endcase
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = W'($urandom_range(1, 300));
        3: b = -W'($urandom_range(1, 300));
        default: ;
      endcase
      run_op(o, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
